// File: rtl/cvxif_offload_if.sv
// Coprocessor-facing CV-X-IF bundle: issue, operand and result handshakes.
// The host drives the master modport and the coprocessor drives the slave modport.
interface cvxif_offload_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_req_instr;
  logic        issue_resp_accept;
  logic        issue_resp_writeback;
  logic [1:0]  issue_resp_register_read;

  logic        register_valid;
  logic        register_ready;
  logic [31:0] register_rs [0:1];
  logic [1:0]  register_rs_valid;

  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_data;

  modport master (
    output issue_valid, issue_req_instr,
    input  issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
    output register_valid, register_rs, register_rs_valid,
    input  register_ready,
    input  result_valid, result_data,
    output result_ready
  );

  modport slave (
    input  issue_valid, issue_req_instr,
    output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
    input  register_valid, register_rs, register_rs_valid,
    output register_ready,
    output result_valid, result_data,
    input  result_ready
  );
endinterface

// File: rtl/cvxif_offload_host.sv
// Host offload stage: issues one instruction to a CV-X-IF coprocessor, supplies
// operands from a local 32x32 register file and writes the result back to rd.
module cvxif_offload_host #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        done_valid,
  output logic        done_illegal,
  output logic        done_timeout,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  input  logic [4:0]  rf_raddr,
  output logic [31:0] rf_rdata,
  cvxif_offload_if.master cx
);

  typedef enum logic [2:0] {IDLE, ISSUE, REGS, RESULT, DONE} state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        wb_q, wb_d;
  logic [1:0]  rs_valid_q, rs_valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic        instr_ready_q, instr_ready_d;
  logic        issue_valid_q, issue_valid_d;
  logic        register_valid_q, register_valid_d;
  logic        result_ready_q, result_ready_d;
  logic        done_valid_q, done_valid_d;

  logic [4:0]  rd, rs1, rs2;

  assign rd  = instr_q[11:7];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    wb_d       = wb_q;
    rs_valid_d = rs_valid_q;
    cnt_d      = cnt_q;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;
    rf_d       = rf_q;

    unique case (state_q)
      IDLE: begin
        if (rf_we && (rf_waddr != 5'd0)) begin
          rf_d[rf_waddr] = rf_wdata;
        end
        if (instr_valid) begin
          instr_d    = instr;
          wb_d       = 1'b0;
          rs_valid_d = 2'b00;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (cx.issue_ready) begin
          if (cx.issue_resp_accept) begin
            wb_d       = cx.issue_resp_writeback;
            rs_valid_d = cx.issue_resp_register_read;
            cnt_d      = 16'd0;
            state_d    = (cx.issue_resp_register_read != 2'b00) ? REGS : RESULT;
          end else begin
            illegal_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      REGS: begin
        if (cx.register_ready) begin
          cnt_d   = 16'd0;
          state_d = RESULT;
        end
      end
      RESULT: begin
        // A result arriving in the final wait cycle beats the timeout.
        if (cx.result_valid) begin
          if (wb_q && (rd != 5'd0)) begin
            rf_d[rd] = cx.result_data;
          end
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    instr_ready_d    = (state_d == IDLE);
    issue_valid_d    = (state_d == ISSUE);
    register_valid_d = (state_d == REGS);
    result_ready_d   = (state_d == RESULT);
    done_valid_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      instr_q          <= '0;
      wb_q             <= 1'b0;
      rs_valid_q       <= 2'b00;
      cnt_q            <= '0;
      illegal_q        <= 1'b0;
      timeout_q        <= 1'b0;
      instr_ready_q    <= 1'b1;
      issue_valid_q    <= 1'b0;
      register_valid_q <= 1'b0;
      result_ready_q   <= 1'b0;
      done_valid_q     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      instr_q          <= instr_d;
      wb_q             <= wb_d;
      rs_valid_q       <= rs_valid_d;
      cnt_q            <= cnt_d;
      illegal_q        <= illegal_d;
      timeout_q        <= timeout_d;
      instr_ready_q    <= instr_ready_d;
      issue_valid_q    <= issue_valid_d;
      register_valid_q <= register_valid_d;
      result_ready_q   <= result_ready_d;
      done_valid_q     <= done_valid_d;
      rf_q             <= rf_d;
    end
  end

  assign instr_ready  = instr_ready_q;
  assign done_valid   = done_valid_q;
  assign done_illegal = illegal_q;
  assign done_timeout = timeout_q;
  assign rf_rdata     = rf_q[rf_raddr];

  // Operands track the register file live, so a stalled REGS sees current contents.
  assign cx.issue_valid          = issue_valid_q;
  assign cx.issue_req_instr      = instr_q;
  assign cx.register_valid       = register_valid_q;
  assign cx.register_rs_valid    = rs_valid_q;
  assign cx.register_rs[0]       = rs_valid_q[0] ? rf_q[rs1] : 32'd0;
  assign cx.register_rs[1]       = rs_valid_q[1] ? rf_q[rs2] : 32'd0;
  assign cx.result_ready         = result_ready_q;

endmodule

// File: tb/tb_cvxif_offload_host.sv
// Directed bench for cvxif_offload_host: the bench plays the coprocessor stub
// and checks each step against hand-computed values.
module tb_cvxif_offload_host;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        done_valid;
  logic        done_illegal;
  logic        done_timeout;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;

  int tests;
  int failed;

  cvxif_offload_if cx ();

  cvxif_offload_host #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .done_valid   (done_valid),
    .done_illegal (done_illegal),
    .done_timeout (done_timeout),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .cx           (cx.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_rf(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    rf_raddr = addr;
    #1;
    check(tag, rf_rdata, exp);
  endtask

  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    rf_we    = 1'b1;
    rf_waddr = addr;
    rf_wdata = data;
    step();
    rf_we    = 1'b0;
  endtask

  // Offer an instruction in IDLE together with the stub's issue response.
  task automatic offer(input logic [31:0] word, input logic rdy, input logic acc,
                       input logic wb, input logic [1:0] rr);
    instr                       = word;
    instr_valid                 = 1'b1;
    cx.issue_ready              = rdy;
    cx.issue_resp_accept        = acc;
    cx.issue_resp_writeback     = wb;
    cx.issue_resp_register_read = rr;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    rf_we = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_raddr = '0;
    cx.issue_ready = 1'b0;
    cx.issue_resp_accept = 1'b0;
    cx.issue_resp_writeback = 1'b0;
    cx.issue_resp_register_read = 2'b00;
    cx.register_ready = 1'b0;
    cx.result_valid = 1'b0;
    cx.result_data = '0;

    step();
    step();
    rst = 1'b0;
    check("reset_instr_ready", instr_ready, 1);
    check("reset_issue_valid", cx.issue_valid, 0);
    check("reset_register_valid", cx.register_valid, 0);
    check("reset_result_ready", cx.result_ready, 0);
    check("reset_done_valid", done_valid, 0);
    check("reset_rs_valid", cx.register_rs_valid, 0);
    check("reset_req_instr", cx.issue_req_instr, 0);

    // Add path: x1 + x2 -> x3, zero-wait stub
    preload(5'd1, 32'h0003_0002);
    preload(5'd2, 32'h0005_0004);
    cx.register_ready = 1'b0;
    offer(32'h0020_818B, 1'b1, 1'b1, 1'b1, 2'b11);
    check("add_issue_valid", cx.issue_valid, 1);
    check("add_req_instr", cx.issue_req_instr, 32'h0020_818B);
    check("add_instr_ready_busy", instr_ready, 0);
    step();
    check("add_register_valid", cx.register_valid, 1);
    check("add_rs_valid", cx.register_rs_valid, 2'b11);
    check("add_rs0", cx.register_rs[0], 32'h0003_0002);
    check("add_rs1", cx.register_rs[1], 32'h0005_0004);
    cx.register_ready = 1'b1;
    step();
    cx.register_ready = 1'b0;
    check("add_result_ready", cx.result_ready, 1);
    check("add_no_done_early", done_valid, 0);
    cx.result_valid = 1'b1;
    cx.result_data = 32'h0008_0006;
    step();
    cx.result_valid = 1'b0;
    check("add_done_valid", done_valid, 1);
    check("add_done_illegal", done_illegal, 0);
    check("add_done_timeout", done_timeout, 0);
    check_rf("add_rf3", 5'd3, 32'h0008_0006);
    step();
    check("add_done_one_cycle", done_valid, 0);
    check("add_back_idle", instr_ready, 1);

    // Conjugate path: only rs1 requested
    preload(5'd1, 32'h1234_5678);
    preload(5'd2, 32'hFFFF_FFFF);
    offer(32'h0020_920B, 1'b1, 1'b1, 1'b1, 2'b01);
    step();
    check("conj_rs_valid", cx.register_rs_valid, 2'b01);
    check("conj_rs0", cx.register_rs[0], 32'h1234_5678);
    check("conj_rs1_zero", cx.register_rs[1], 32'h0);
    cx.register_ready = 1'b1;
    step();
    cx.register_ready = 1'b0;
    cx.result_valid = 1'b1;
    cx.result_data = 32'hEDCC_5678;
    step();
    cx.result_valid = 1'b0;
    check("conj_done_valid", done_valid, 1);
    check_rf("conj_rf4", 5'd4, 32'hEDCC_5678);
    step();

    // Reject: issue_ready=1, accept=0
    offer(32'h0020_82B3, 1'b1, 1'b0, 1'b1, 2'b11);
    check("rej_no_regs_issue", cx.register_valid, 0);
    step();
    check("rej_done_valid", done_valid, 1);
    check("rej_done_illegal", done_illegal, 1);
    check("rej_done_timeout", done_timeout, 0);
    check("rej_no_regs_done", cx.register_valid, 0);
    check_rf("rej_rf5", 5'd5, 32'h0);
    check_rf("rej_rf1", 5'd1, 32'h1234_5678);
    step();
    check("rej_flag_clear", done_illegal, 0);

    // Backpressure: issue stalls 5 cycles, operands stall 3 cycles
    offer(32'h0020_830B, 1'b0, 1'b1, 1'b1, 2'b11);
    rf_we = 1'b1;
    rf_waddr = 5'd1;
    rf_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      check("bp_issue_valid", cx.issue_valid, 1);
      check("bp_req_instr", cx.issue_req_instr, 32'h0020_830B);
      step();
    end
    rf_we = 1'b0;
    cx.issue_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("bp_register_valid", cx.register_valid, 1);
      check("bp_rs0", cx.register_rs[0], 32'h1234_5678);
      check("bp_rs1", cx.register_rs[1], 32'hFFFF_FFFF);
      step();
    end
    cx.register_ready = 1'b1;
    step();
    cx.register_ready = 1'b0;
    cx.result_valid = 1'b1;
    cx.result_data = 32'hCAFE_F00D;
    step();
    cx.result_valid = 1'b0;
    check("bp_done_valid", done_valid, 1);
    check_rf("bp_rf6", 5'd6, 32'hCAFE_F00D);
    check_rf("bp_rf3_untouched", 5'd3, 32'h0008_0006);
    step();
    check_rf("bp_rf6_after", 5'd6, 32'hCAFE_F00D);

    // Timeout: 8 RESULT cycles with no result
    preload(5'd7, 32'h7777_7777);
    offer(32'h0000_038B, 1'b1, 1'b1, 1'b1, 2'b00);
    step();
    for (int i = 0; i < 8; i++) begin
      check("tmo_result_ready", cx.result_ready, 1);
      check("tmo_no_done", done_valid, 0);
      step();
    end
    check("tmo_done_valid", done_valid, 1);
    check("tmo_done_timeout", done_timeout, 1);
    check("tmo_done_illegal", done_illegal, 0);
    check_rf("tmo_rf7", 5'd7, 32'h7777_7777);
    step();

    // Result in the 8th RESULT cycle wins over the timeout
    offer(32'h0000_040B, 1'b1, 1'b1, 1'b1, 2'b00);
    step();
    for (int i = 0; i < 7; i++) begin
      step();
    end
    check("tmo8_still_waiting", cx.result_ready, 1);
    cx.result_valid = 1'b1;
    cx.result_data = 32'h8888_8888;
    step();
    cx.result_valid = 1'b0;
    check("tmo8_done_valid", done_valid, 1);
    check("tmo8_no_timeout", done_timeout, 0);
    check_rf("tmo8_rf8", 5'd8, 32'h8888_8888);
    step();

    // rd = x0: writes to x0 are dropped
    preload(5'd0, 32'h0000_1234);
    check_rf("x0_preload", 5'd0, 32'h0);
    offer(32'h0000_000B, 1'b1, 1'b1, 1'b1, 2'b00);
    step();
    cx.result_valid = 1'b1;
    cx.result_data = 32'hDEAD_BEEF;
    step();
    cx.result_valid = 1'b0;
    check("x0_done_valid", done_valid, 1);
    check_rf("x0_writeback", 5'd0, 32'h0);
    step();

    // Reset during RESULT abandons the instruction
    offer(32'h0000_048B, 1'b1, 1'b1, 1'b1, 2'b00);
    step();
    check("rst_in_result", cx.result_ready, 1);
    rst = 1'b1;
    cx.result_valid = 1'b1;
    cx.result_data = 32'h9999_9999;
    step();
    rst = 1'b0;
    cx.result_valid = 1'b0;
    check("rst_instr_ready", instr_ready, 1);
    check("rst_done_valid", done_valid, 0);
    check("rst_result_ready", cx.result_ready, 0);
    check("rst_req_instr", cx.issue_req_instr, 0);
    check_rf("rst_rf1", 5'd1, 32'h0);
    check_rf("rst_rf3", 5'd3, 32'h0);
    check_rf("rst_rf9", 5'd9, 32'h0);
    step();
    check("rst_no_done_later", done_valid, 0);
    check("rst_idle_later", instr_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cvxif_offload_host.md
# cvxif_offload_host

Host-side offload stage sitting directly upstream of the CV-X-IF complex-number coprocessor. It accepts one instruction word at a time, issues it on the coprocessor issue interface, and supplies source operands from a local 32×32 register file. It then collects the coprocessor result and writes it back to `rd`. It stands in for the CPU core's offload path in tutorial systems and benches.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent waiting for `result_valid` before the operation is abandoned; range 2..65535.
- `clk` in 1: clock; everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: an instruction is offered.
- `instr_ready` out 1: host can take an instruction.
- `instr` in 32: RISC-V instruction word.
- `done_valid` out 1: one-cycle completion pulse.
- `done_illegal` out 1: qualifies `done_valid`; the coprocessor rejected the instruction.
- `done_timeout` out 1: qualifies `done_valid`; the result wait timed out.
- `rf_we` in 1: external register-file write (preload).
- `rf_waddr` in 5: external write address.
- `rf_wdata` in 32: external write data.
- `rf_raddr` in 5: debug read address.
- `rf_rdata` out 32: combinational read of `rf[rf_raddr]`.
- `issue_valid` out 1: issue request to the coprocessor.
- `issue_ready` in 1: coprocessor issue ready.
- `issue_req_instr` out 32: instruction offered to the coprocessor.
- `issue_resp_accept` in 1: coprocessor accepts; sampled only while `issue_valid && issue_ready`.
- `issue_resp_writeback` in 1: result will be written back.
- `issue_resp_register_read` in 2: bit0 = rs1 needed, bit1 = rs2 needed.
- `register_valid` out 1: operands valid.
- `register_ready` in 1: operand handshake ready.
- `register_rs` out 2×32: array [0:1]; [0] = `rf[rs1]`, [1] = `rf[rs2]`.
- `register_rs_valid` out 2: latched `issue_resp_register_read`.
- `result_valid` in 1: coprocessor result valid.
- `result_ready` out 1: host ready for the result.
- `result_data` in 32: result value.

## Operation
- Field decode: `rd` = `instr[11:7]`, `rs1` = `instr[19:15]`, `rs2` = `instr[24:20]`.
- Register x0 reads 0 and ignores all writes.
- FSM states: IDLE, ISSUE, REGS, RESULT, DONE.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`, latch `instr`, clear flags, go to ISSUE.
  - `rf_we` is honoured only in IDLE and ignored in every other state.
- ISSUE:
  - `issue_valid`=1 and `issue_req_instr` = latched instruction, held stable until `issue_ready`.
  - On `issue_ready && issue_resp_accept`: latch `register_read` and `writeback`. Go to REGS if `register_read`≠00, else go to RESULT.
  - On `issue_ready && !issue_resp_accept`: set `done_illegal` and go to DONE.
- REGS:
  - `register_valid`=1.
  - `register_rs[0]`/`[1]` are read from the register file each cycle, zero when the matching `register_rs_valid` bit is 0.
  - On `register_ready`, go to RESULT.
- RESULT:
  - `result_ready`=1; the wait counter increments each cycle, starting from 0 on entry.
  - On `result_valid`: if `writeback` && `rd`≠0, write `rf[rd]=result_data`; go to DONE.
  - If the counter reaches `TIMEOUT`-1 without `result_valid`: set `done_timeout`, drop the result, go to DONE.
  - `result_valid` in the timeout cycle takes priority; the result is written back and no timeout is flagged.
- DONE: `done_valid`=1 for exactly one cycle with the flags, then go to IDLE.
- Flags are mutually exclusive and read 0 whenever `done_valid`=0.

## Timing
- Reset:
  - FSM goes to IDLE; all 32 registers are cleared.
  - `instr_ready`=1 in the first cycle after reset.
  - All other outputs are 0: `issue_valid`, `register_valid`, `result_ready`, `done_*`, `register_rs_valid`, and `issue_req_instr`=0.
- A reset mid-operation abandons the instruction with no writeback and no `done_valid`.
- Minimum latency, instruction accepted to `done_valid`, with a zero-wait coprocessor: ISSUE(1) + REGS(1) + RESULT(1) + DONE = `done_valid` in the 4th cycle after the `instr` handshake.
- A writeback is visible on `rf_rdata` in the cycle after the `result_valid` handshake.
- An rs read in REGS observes all completed earlier writebacks.
- `instr_ready` is 0 from ISSUE through DONE; there is no overlap between instructions.

## Test plan
- Add path:
  - Stimulus: preload x1=0x00030002, x2=0x00050004; issue funct3=000, rs1=1, rs2=2, rd=3; stub coprocessor returns `rs[0]+rs[1]`.
  - Required: `register_rs_valid`=11, `register_rs`={0x00030002,0x00050004}, `rf[3]`=0x00080006, `done_valid` with no flags.
- Conjugate path:
  - Stimulus: `register_read`=01, x1=0x12345678, x2=0xFFFFFFFF.
  - Required: `register_rs[1]`=0, `register_rs_valid`=01, `rf[rd]` equals the stub result.
- Reject:
  - Stimulus: instruction with opcode 0110011; stub drives `issue_ready`=1, `accept`=0.
  - Required: `done_valid`+`done_illegal` two cycles later, REGS never entered, no register changes.
- Backpressure:
  - Stimulus: `issue_ready` low for 5 cycles, `register_ready` low for 3 cycles.
  - Required: `issue_req_instr` and `register_rs` stay stable throughout, and exactly one writeback occurs.
- Timeout:
  - Stimulus: `TIMEOUT`=8, `result_valid` never asserted.
  - Required: `done_timeout` pulse after 8 RESULT cycles, `rf[rd]` unchanged; a second variant asserting `result_valid` in the 8th cycle gets a writeback with no timeout.
- rd=x0 and reset:
  - Stimulus: run with `rd`=0; separately assert `rst` during RESULT.
  - Required: x0 stays 0; after reset all registers are 0, `instr_ready`=1, no `done_valid`.
